// File: rtl/riscv_branch_pkg.sv
// Shared branch definitions: funct3 encodings understood by branch_comparator,
// the resolve-controller state encoding and the sequential PC step.
package riscv_branch_pkg;

  localparam logic [2:0] FUNCT3_BEQ = 3'b000;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_OPS,
    ST_RESOLVE,
    ST_REDIRECT
  } br_state_e;

endpackage

// File: rtl/branch_perf_counter.sv
// Saturating event counter for the branch perf CSRs; sticks at all-ones.
module branch_perf_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  // NOTE: flops use <= so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution sequencer: waits for operands, feeds the shared
// comparator, checks the BTFN guess and redirects fetch on a mispredict.
module branch_resolve_ctrl
  import riscv_branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   br_valid_i,
  output logic                   br_ready_o,
  input  logic [2:0]             br_funct3_i,
  input  logic [DATA_WIDTH-1:0]  br_pc_i,
  input  logic [DATA_WIDTH-1:0]  br_imm_i,
  input  logic [DATA_WIDTH-1:0]  rs1_data_i,
  input  logic [DATA_WIDTH-1:0]  rs2_data_i,
  input  logic                   rs1_ready_i,
  input  logic                   rs2_ready_i,
  output logic [DATA_WIDTH-1:0]  cmp_rs1_o,
  output logic [DATA_WIDTH-1:0]  cmp_rs2_o,
  output logic [2:0]             cmp_funct3_o,
  input  logic                   cmp_taken_i,
  output logic                   stall_o,
  output logic                   redirect_valid_o,
  output logic [DATA_WIDTH-1:0]  redirect_pc_o,
  input  logic                   redirect_ready_i,
  output logic                   flush_o,
  output logic                   resolved_o,
  input  logic                   kill_i,
  output logic [COUNT_WIDTH-1:0] br_count_o,
  output logic [COUNT_WIDTH-1:0] mispred_count_o
);

  br_state_e             state_d, state_q;
  logic [DATA_WIDTH-1:0] pc_d, pc_q, imm_d, imm_q;
  logic [2:0]            funct3_d, funct3_q, cmp_funct3_d, cmp_funct3_q;
  logic                  pred_d, pred_q;
  logic [DATA_WIDTH-1:0] cmp_rs1_d, cmp_rs1_q, cmp_rs2_d, cmp_rs2_q;
  logic [DATA_WIDTH-1:0] redirect_pc_d, redirect_pc_q;
  logic                  flush_d, flush_q, resolved_d, resolved_q;
  logic                  br_inc, mis_inc;
  logic [DATA_WIDTH-1:0] actual_pc;
  logic                  mispredict;

  // Address arithmetic wraps modulo 2^DATA_WIDTH by construction.
  assign actual_pc  = cmp_taken_i ? (pc_q + imm_q) : (pc_q + DATA_WIDTH'(PC_STEP));
  assign mispredict = cmp_taken_i ^ pred_q;

  // NOTE: every always_comb target is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    funct3_d      = funct3_q;
    pred_d        = pred_q;
    cmp_rs1_d     = cmp_rs1_q;
    cmp_rs2_d     = cmp_rs2_q;
    cmp_funct3_d  = cmp_funct3_q;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;
    resolved_d    = 1'b0;
    br_inc        = 1'b0;
    mis_inc       = 1'b0;

    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (br_valid_i) begin
            pc_d     = br_pc_i;
            imm_d    = br_imm_i;
            funct3_d = br_funct3_i;
            pred_d   = br_imm_i[DATA_WIDTH-1];  // backward taken, forward not taken
            state_d  = ST_WAIT_OPS;
          end
        end
        ST_WAIT_OPS: begin
          if (rs1_ready_i && rs2_ready_i) begin
            cmp_rs1_d    = rs1_data_i;
            cmp_rs2_d    = rs2_data_i;
            cmp_funct3_d = funct3_q;
            state_d      = ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          br_inc = 1'b1;
          if (mispredict) begin
            mis_inc       = 1'b1;
            redirect_pc_d = actual_pc;
            flush_d       = 1'b1;
            state_d       = ST_REDIRECT;
          end else begin
            resolved_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready_i) begin
            resolved_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      imm_q         <= '0;
      funct3_q      <= '0;
      pred_q        <= 1'b0;
      cmp_rs1_q     <= '0;
      cmp_rs2_q     <= '0;
      cmp_funct3_q  <= '0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      resolved_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      funct3_q      <= funct3_d;
      pred_q        <= pred_d;
      cmp_rs1_q     <= cmp_rs1_d;
      cmp_rs2_q     <= cmp_rs2_d;
      cmp_funct3_q  <= cmp_funct3_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      resolved_q    <= resolved_d;
    end
  end

  branch_perf_counter #(.WIDTH(COUNT_WIDTH)) u_br_count (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (br_inc),
    .count_o (br_count_o)
  );

  branch_perf_counter #(.WIDTH(COUNT_WIDTH)) u_mispred_count (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (mis_inc),
    .count_o (mispred_count_o)
  );

  assign br_ready_o       = (state_q == ST_IDLE);
  assign stall_o          = (state_q != ST_IDLE);
  assign redirect_valid_o = (state_q == ST_REDIRECT);
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = flush_q;
  assign resolved_o       = resolved_q;
  assign cmp_rs1_o        = cmp_rs1_q;
  assign cmp_rs2_o        = cmp_rs2_q;
  assign cmp_funct3_o     = cmp_funct3_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed table, random branches against a
// per-branch outcome model, kill/reset corners, and a narrow-counter twin for saturation.
module tb_branch_resolve_ctrl;
  import riscv_branch_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          br_valid_i = 1'b0;
  logic [2:0]    br_funct3_i = '0;
  logic [DW-1:0] br_pc_i = '0, br_imm_i = '0;
  logic [DW-1:0] rs1_data_i = '0, rs2_data_i = '0;
  logic          rs1_ready_i = 1'b0, rs2_ready_i = 1'b0;
  logic          redirect_ready_i = 1'b0;
  logic          kill_i = 1'b0;

  logic          br_ready_o, stall_o, redirect_valid_o, flush_o, resolved_o;
  logic [DW-1:0] cmp_rs1_o, cmp_rs2_o, redirect_pc_o;
  logic [2:0]    cmp_funct3_o;
  logic          cmp_taken;
  logic [CW-1:0] br_count_o, mispred_count_o;

  logic          s_br_ready, s_stall, s_redirect_valid, s_flush, s_resolved;
  logic [DW-1:0] s_cmp_rs1, s_cmp_rs2, s_redirect_pc;
  logic [2:0]    s_cmp_funct3;
  logic          s_cmp_taken;
  logic [SW-1:0] s_br_count, s_mispred_count;

  int vectors_applied = 0;
  int miscompares     = 0;
  int br_n  = 0;
  int mis_n = 0;
  logic [DW-1:0] last_rs1 = '0, last_rs2 = '0;

  typedef struct {
    logic [2:0]    f3;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    int            ops_delay;
    int            rdy_delay;
    logic          exp_mis;
    logic [DW-1:0] exp_pc;
  } vec_t;

  always #5 clk_i = ~clk_i;

  // The comparator that the parent instantiates: BEQ/BNE only, anything else not taken.
  function automatic logic cmp_model(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (f3 == FUNCT3_BEQ) return a == b;
    if (f3 == FUNCT3_BNE) return a != b;
    return 1'b0;
  endfunction

  always_comb cmp_taken   = cmp_model(cmp_funct3_o, cmp_rs1_o, cmp_rs2_o);
  always_comb s_cmp_taken = cmp_model(s_cmp_funct3, s_cmp_rs1, s_cmp_rs2);

  branch_resolve_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .br_valid_i(br_valid_i), .br_ready_o(br_ready_o), .br_funct3_i(br_funct3_i),
    .br_pc_i(br_pc_i), .br_imm_i(br_imm_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rs1_ready_i(rs1_ready_i), .rs2_ready_i(rs2_ready_i),
    .cmp_rs1_o(cmp_rs1_o), .cmp_rs2_o(cmp_rs2_o), .cmp_funct3_o(cmp_funct3_o),
    .cmp_taken_i(cmp_taken), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i), .flush_o(flush_o), .resolved_o(resolved_o),
    .kill_i(kill_i), .br_count_o(br_count_o), .mispred_count_o(mispred_count_o)
  );

  branch_resolve_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(SW)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .br_valid_i(br_valid_i), .br_ready_o(s_br_ready), .br_funct3_i(br_funct3_i),
    .br_pc_i(br_pc_i), .br_imm_i(br_imm_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rs1_ready_i(rs1_ready_i), .rs2_ready_i(rs2_ready_i),
    .cmp_rs1_o(s_cmp_rs1), .cmp_rs2_o(s_cmp_rs2), .cmp_funct3_o(s_cmp_funct3),
    .cmp_taken_i(s_cmp_taken), .stall_o(s_stall),
    .redirect_valid_o(s_redirect_valid), .redirect_pc_o(s_redirect_pc),
    .redirect_ready_i(redirect_ready_i), .flush_o(s_flush), .resolved_o(s_resolved),
    .kill_i(kill_i), .br_count_o(s_br_count), .mispred_count_o(s_mispred_count)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sat(input int n, input int w);
    int max_v;
    max_v = (1 << w) - 1;
    return (n > max_v) ? max_v : n;
  endfunction

  task automatic check_counts();
    check("br_count",       br_count_o,      sat(br_n, CW));
    check("mispred_count",  mispred_count_o, sat(mis_n, CW));
    check("sat_br_count",   s_br_count,      sat(br_n, SW));
    check("sat_mis_count",  s_mispred_count, sat(mis_n, SW));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_br_ready"}, br_ready_o, 1);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_redirect_valid"}, redirect_valid_o, 0);
    check({tag, "_flush"}, flush_o, 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Behavioural outcome of one branch: BTFN guess versus the architectural result.
  function automatic vec_t make_vec(input logic [2:0] f3, input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                                    input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                                    input int od, input int rd);
    vec_t v;
    logic taken, guess;
    taken = (f3 == 3'b000) ? (rs1 == rs2) : (f3 == 3'b001) ? (rs1 != rs2) : 1'b0;
    guess = $signed(imm) < 0;
    v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.ops_delay = od; v.rdy_delay = rd;
    v.exp_mis = taken != guess;
    v.exp_pc  = taken ? pc + imm : pc + 32'd4;
    return v;
  endfunction

  // abort: 0 none, 1 kill in WAIT_OPS, 2 kill in RESOLVE, 3 kill in REDIRECT, 4 reset in REDIRECT
  task automatic run_branch(input vec_t v, input int abort);
    logic [DW-1:0] held_pc;
    check_idle("idle");
    br_valid_i  = 1'b1;
    br_funct3_i = v.f3;
    br_pc_i     = v.pc;
    br_imm_i    = v.imm;
    tick();
    br_valid_i = 1'b0;
    br_pc_i    = $urandom;
    br_imm_i   = $urandom;
    check("wait_br_ready", br_ready_o, 0);
    check("wait_stall", stall_o, 1);
    if (abort == 1) begin
      kill_i = 1'b1;
      tick();
      kill_i = 1'b0;
      check_idle("kill_wait");
      check("kill_wait_resolved", resolved_o, 0);
      check("kill_wait_cmp_rs1", cmp_rs1_o, last_rs1);
      check_counts();
      return;
    end
    for (int d = 0; d < v.ops_delay; d++) begin
      rs1_ready_i = 1'($urandom_range(0, 1));
      rs2_ready_i = 1'b0;
      rs1_data_i  = $urandom;
      rs2_data_i  = $urandom;
      tick();
      check("ops_stall", stall_o, 1);
      check("ops_br_ready", br_ready_o, 0);
      check("ops_cmp_rs1_held", cmp_rs1_o, last_rs1);
      check("ops_cmp_rs2_held", cmp_rs2_o, last_rs2);
    end
    rs1_ready_i = 1'b1;
    rs2_ready_i = 1'b1;
    rs1_data_i  = v.rs1;
    rs2_data_i  = v.rs2;
    tick();
    rs1_ready_i = 1'b0;
    rs2_ready_i = 1'b0;
    rs1_data_i  = $urandom;
    rs2_data_i  = $urandom;
    last_rs1 = v.rs1;
    last_rs2 = v.rs2;
    check("res_cmp_rs1", cmp_rs1_o, v.rs1);
    check("res_cmp_rs2", cmp_rs2_o, v.rs2);
    check("res_cmp_funct3", cmp_funct3_o, v.f3);
    check("res_stall", stall_o, 1);
    check("res_resolved", resolved_o, 0);
    if (abort == 2) begin
      kill_i = 1'b1;
      tick();
      kill_i = 1'b0;
      check_idle("kill_res");
      check("kill_res_resolved", resolved_o, 0);
      check_counts();
      return;
    end
    tick();
    br_n++;
    if (v.exp_mis) mis_n++;
    check_counts();
    if (!v.exp_mis) begin
      check("ok_resolved", resolved_o, 1);
      check_idle("ok");
      tick();
      check("ok_resolved_pulse", resolved_o, 0);
      return;
    end
    check("mis_flush", flush_o, 1);
    check("mis_redirect_valid", redirect_valid_o, 1);
    check("mis_redirect_pc", redirect_pc_o, v.exp_pc);
    check("mis_resolved", resolved_o, 0);
    check("mis_stall", stall_o, 1);
    held_pc = redirect_pc_o;
    if (abort >= 3) begin
      if (abort == 4) rst_ni = 1'b0;
      else            kill_i = 1'b1;
      tick();
      kill_i = 1'b0;
      rst_ni = 1'b1;
      if (abort == 4) begin
        br_n = 0; mis_n = 0; last_rs1 = '0; last_rs2 = '0;
        check("rst_cmp_rs1", cmp_rs1_o, 0);
        check("rst_cmp_funct3", cmp_funct3_o, 0);
        check("rst_redirect_pc", redirect_pc_o, 0);
      end
      check_idle("abort_redir");
      check("abort_redir_resolved", resolved_o, 0);
      check_counts();
      return;
    end
    for (int d = 0; d < v.rdy_delay; d++) begin
      redirect_ready_i = 1'b0;
      tick();
      check("hold_flush", flush_o, 0);
      check("hold_redirect_valid", redirect_valid_o, 1);
      check("hold_redirect_pc", redirect_pc_o, held_pc);
    end
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    check("hs_resolved", resolved_o, 1);
    check_idle("hs");
    check_counts();
    tick();
    check("hs_resolved_pulse", resolved_o, 0);
  endtask

  vec_t table_v[7];

  initial begin
    table_v[0] = '{3'b000, 32'h0000_0100, 32'h0000_0020, 32'd5, 32'd5, 0, 0, 1'b1, 32'h0000_0120};
    table_v[1] = '{3'b001, 32'h0000_0200, 32'hFFFF_FFF8, 32'd1, 32'd2, 0, 0, 1'b0, 32'h0000_01F8};
    table_v[2] = '{3'b000, 32'h0000_0300, 32'hFFFF_FFF0, 32'd7, 32'd7, 3, 0, 1'b0, 32'h0000_02F0};
    table_v[3] = '{3'b001, 32'h0000_0400, 32'h0000_0010, 32'd3, 32'd4, 0, 4, 1'b1, 32'h0000_0410};
    table_v[4] = '{3'b100, 32'hFFFF_FFFC, 32'h0000_0004, 32'd1, 32'd9, 0, 0, 1'b0, 32'h0000_0000};
    table_v[5] = '{3'b000, 32'hFFFF_FFFC, 32'hFFFF_FF00, 32'd1, 32'd2, 1, 2, 1'b1, 32'h0000_0000};
    table_v[6] = '{3'b001, 32'hFFFF_FFF0, 32'h0000_0020, 32'd1, 32'd2, 0, 1, 1'b1, 32'h0000_0010};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_idle("reset");
    check("reset_resolved", resolved_o, 0);
    check("reset_redirect_pc", redirect_pc_o, 0);
    check("reset_cmp_rs1", cmp_rs1_o, 0);
    check("reset_cmp_rs2", cmp_rs2_o, 0);
    check("reset_cmp_funct3", cmp_funct3_o, 0);
    check_counts();
    rst_ni = 1'b1;
    tick();

    foreach (table_v[i]) run_branch(table_v[i], 0);

    // kill wins over a simultaneous branch offer
    br_valid_i  = 1'b1;
    kill_i      = 1'b1;
    br_funct3_i = 3'b000;
    tick();
    br_valid_i = 1'b0;
    kill_i     = 1'b0;
    check_idle("kill_vs_valid");
    tick();
    check_idle("kill_vs_valid_next");

    run_branch(table_v[2], 1);
    run_branch(table_v[0], 3);
    run_branch(table_v[3], 2);
    run_branch(table_v[1], 0);

    for (int n = 0; n < 80; n++) begin
      logic [2:0]    f3;
      logic [DW-1:0] imm;
      int            abort;
      case ($urandom_range(0, 3))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b100;
        default: f3 = 3'($urandom);
      endcase
      imm = DW'($urandom_range(1, 255)) << 1;
      if ($urandom_range(0, 1) == 1) imm = -imm;
      abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_branch(make_vec(f3, $urandom & 32'hFFFF_FFFC, imm, DW'($urandom_range(0, 3)),
                          DW'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3)), abort);
    end

    run_branch(table_v[6], 4);
    run_branch(table_v[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
